// File: rtl/qu_common_pkg.sv
// rtl/qu_common_pkg.sv - shared reservation-station types and issue FSM encoding
package qu_common;

    localparam int RES_ST_DEPTH = 16;
    localparam int RES_ST_AW    = $clog2(RES_ST_DEPTH);

    typedef logic [RES_ST_AW-1:0] res_st_addr_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [5:0]  prd;
        logic [31:0] imm;
    } res_st_cell_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        ISSUE = 2'd2
    } issue_state_t;

    // Depth is a power of two, so the natural address overflow is the wrap.
    function automatic res_st_addr_t next_addr(input res_st_addr_t a);
        return a + res_st_addr_t'(1);
    endfunction

endpackage

// File: rtl/qu_rr_picker.sv
// rtl/qu_rr_picker.sv - combinational round-robin find-first over a request vector
module qu_rr_picker
    import qu_common::*;
#(
    parameter int DEPTH = RES_ST_DEPTH
) (
    input  logic [DEPTH-1:0] i_req,
    input  res_st_addr_t     i_rr_ptr,
    output res_st_addr_t     o_pick,
    output logic             o_pick_valid
);

    res_st_addr_t w_idx;

    // Walk offsets high to low so the smallest offset from the pointer wins.
    always_comb begin
        o_pick       = '0;
        o_pick_valid = 1'b0;
        w_idx        = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_idx = i_rr_ptr + res_st_addr_t'(k);
            if (i_req[w_idx]) begin
                o_pick       = w_idx;
                o_pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/qu_issue_unit.sv
// rtl/qu_issue_unit.sv - reservation-station select/read/issue stage with flush
module qu_issue_unit
    import qu_common::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [RES_ST_DEPTH-1:0] rs_busy_in,
    input  logic [RES_ST_DEPTH-1:0] rs_ready_in,
    output res_st_addr_t            rs_rd_addr_out,
    input  res_st_cell_t            rs_rd_data_in,
    output logic                    rs_free_en_out,
    output res_st_addr_t            rs_free_addr_out,
    output logic                    eu_valid_out,
    input  logic                    eu_ready_in,
    output res_st_cell_t            eu_uop_out,
    output res_st_addr_t            eu_tag_out,
    input  logic                    issue_stall_in,
    input  logic                    flush_in,
    output logic                    busy_out,
    output logic [CNT_WIDTH-1:0]    issued_cnt_out
);

    issue_state_t r_state;
    issue_state_t w_next_state;
    res_st_addr_t r_tag;
    res_st_addr_t r_rr_ptr;

    logic [RES_ST_DEPTH-1:0] w_cand;
    res_st_addr_t            w_pick;
    logic                    w_pick_valid;
    logic                    w_start;
    logic                    w_read_ok;
    logic                    w_accept;

    assign w_cand    = rs_busy_in & rs_ready_in;
    assign w_start   = w_pick_valid & ~issue_stall_in & ~flush_in;
    assign w_read_ok = ~flush_in & rs_busy_in[r_tag];
    assign w_accept  = eu_ready_in & ~flush_in;
    assign busy_out  = (r_state != IDLE);

    qu_rr_picker #(
        .DEPTH        (RES_ST_DEPTH)
    ) u_picker (
        .i_req        (w_cand),
        .i_rr_ptr     (r_rr_ptr),
        .o_pick       (w_pick),
        .o_pick_valid (w_pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next_state = READ;
            READ:    w_next_state = w_read_ok ? ISSUE : IDLE;
            ISSUE:   if (flush_in || eu_ready_in) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Entry loss in READ (busy dropped) abandons the issue without a free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag            <= '0;
            r_rr_ptr         <= '0;
            rs_rd_addr_out   <= '0;
            rs_free_en_out   <= 1'b0;
            rs_free_addr_out <= '0;
            eu_valid_out     <= 1'b0;
            eu_uop_out       <= '0;
            eu_tag_out       <= '0;
            issued_cnt_out   <= '0;
        end else begin
            rs_free_en_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        rs_rd_addr_out <= w_pick;
                        r_tag          <= w_pick;
                    end
                end
                READ: begin
                    if (w_read_ok) begin
                        eu_uop_out   <= rs_rd_data_in;
                        eu_tag_out   <= r_tag;
                        eu_valid_out <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (flush_in) begin
                        eu_valid_out <= 1'b0;
                    end else if (w_accept) begin
                        rs_free_en_out   <= 1'b1;
                        rs_free_addr_out <= r_tag;
                        issued_cnt_out   <= issued_cnt_out + 1'b1;
                        r_rr_ptr         <= next_addr(r_tag);
                        eu_valid_out     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qu_issue_unit.sv
// tb/tb_qu_issue_unit.sv - scoreboard bench for qu_issue_unit with a transaction-level reference
module tb_qu_issue_unit;
    import qu_common::*;

    localparam int D  = RES_ST_DEPTH;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [D-1:0]      rs_busy;
    logic [D-1:0]      rs_ready;
    res_st_addr_t      rs_rd_addr;
    res_st_cell_t      rs_rd_data;
    logic              rs_free_en;
    res_st_addr_t      rs_free_addr;
    logic              eu_valid;
    logic              eu_ready;
    res_st_cell_t      eu_uop;
    res_st_addr_t      eu_tag;
    logic              stall;
    logic              flush;
    logic              busy;
    logic [CW-1:0]     issued_cnt;

    res_st_cell_t mem [D];
    assign rs_rd_data = mem[rs_rd_addr];

    qu_issue_unit #(.CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs_busy_in       (rs_busy),
        .rs_ready_in      (rs_ready),
        .rs_rd_addr_out   (rs_rd_addr),
        .rs_rd_data_in    (rs_rd_data),
        .rs_free_en_out   (rs_free_en),
        .rs_free_addr_out (rs_free_addr),
        .eu_valid_out     (eu_valid),
        .eu_ready_in      (eu_ready),
        .eu_uop_out       (eu_uop),
        .eu_tag_out       (eu_tag),
        .issue_stall_in   (stall),
        .flush_in         (flush),
        .busy_out         (busy),
        .issued_cnt_out   (issued_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        res_st_cell_t uop;
    } exp_t;

    exp_t          expq[$];
    int            acc_tags[$];
    int            n_cmp = 0;
    int            n_err = 0;

    int            m_phase;
    int            m_rr;
    int            m_tag;
    logic [CW-1:0] m_cnt;
    bit            m_free;
    int            m_free_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick_ref(input logic [D-1:0] c, input int rr);
        for (int k = 0; k < D; k++) begin
            if (c[(rr + k) % D]) return (rr + k) % D;
        end
        return -1;
    endfunction

    // Reference: select (stage 0), read (1), present until accept/flush (2).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_rr = 0; m_tag = 0; m_cnt = '0; m_free = 0; m_free_addr = 0;
            expq.delete();
        end else begin
            int   p;
            exp_t e;
            m_free = 0;
            case (m_phase)
                0: begin
                    p = pick_ref(rs_busy & rs_ready, m_rr);
                    if (!stall && !flush && p >= 0) begin
                        m_tag = p;
                        m_phase = 1;
                    end
                end
                1: begin
                    if (flush || !rs_busy[m_tag]) begin
                        m_phase = 0;
                    end else begin
                        e.tag = m_tag;
                        e.uop = mem[m_tag];
                        expq.push_back(e);
                        m_phase = 2;
                    end
                end
                default: begin
                    if (flush) begin
                        if (expq.size() > 0) void'(expq.pop_back());
                        m_phase = 0;
                    end else if (eu_ready) begin
                        m_free = 1;
                        m_free_addr = m_tag;
                        m_cnt = m_cnt + 1'b1;
                        m_rr = (m_tag + 1) % D;
                        m_phase = 0;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("eu_valid", eu_valid, (m_phase == 2));
            chk("busy_out", busy, (m_phase != 0));
            chk("issued_cnt", issued_cnt, m_cnt);
            chk("free_en", rs_free_en, m_free);
            if (rs_free_en && m_free) chk("free_addr", rs_free_addr, m_free_addr);
            if (eu_valid) begin
                if (expq.size() == 0) begin
                    chk("uop_unexpected", 1, 0);
                end else begin
                    chk("eu_tag", eu_tag, expq[0].tag);
                    chk("eu_uop", eu_uop, expq[0].uop);
                    if (eu_ready && !flush) begin
                        acc_tags.push_back(int'(eu_tag));
                        void'(expq.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        acc_tags.delete();
    endtask

    task automatic set_cand(input logic [D-1:0] v);
        rs_busy = v;
        rs_ready = v;
    endtask

    initial begin
        res_st_cell_t saved;
        for (int i = 0; i < D; i++) mem[i] = res_st_cell_t'({$urandom, $urandom});
        set_cand(16'hFFFF);
        eu_ready = 1'b0; stall = 1'b0; flush = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("rst_rd_addr", rs_rd_addr, 0);
            chk("rst_valid", eu_valid, 0);
        end
        chk("rst_uop", eu_uop, 0);
        chk("rst_tag", eu_tag, 0);
        chk("rst_free_en", rs_free_en, 0);
        chk("rst_free_addr", rs_free_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cnt", issued_cnt, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        tick(2);
        chk("first_valid", eu_valid, 1);
        chk("first_tag", eu_tag, 0);

        do_reset();
        set_cand(16'b1000_0000_0001_0010);
        eu_ready = 1'b1;
        tick(13);
        chk("rr_count", acc_tags.size(), 4);
        if (acc_tags.size() >= 4) begin
            chk("rr_tag0", acc_tags[0], 1);
            chk("rr_tag1", acc_tags[1], 4);
            chk("rr_tag2", acc_tags[2], 15);
            chk("rr_tag3", acc_tags[3], 1);
        end
        chk("rr_cnt", issued_cnt, 4);

        eu_ready = 1'b0;
        tick(2);
        saved = eu_uop;
        chk("bp_valid", eu_valid, 1);
        tick(10);
        chk("bp_hold_valid", eu_valid, 1);
        chk("bp_hold_uop", eu_uop, saved);
        chk("bp_no_free", rs_free_en, 0);
        eu_ready = 1'b1;
        tick(1);
        eu_ready = 1'b0;
        chk("bp_free_pulse", rs_free_en, 1);
        chk("bp_free_addr", rs_free_addr, 4);
        tick(1);
        chk("bp_free_single", rs_free_en, 0);

        do_reset();
        set_cand(16'h0008);
        tick(3);
        chk("fl_pre_valid", eu_valid, 1);
        chk("fl_pre_tag", eu_tag, 3);
        flush = 1'b1; eu_ready = 1'b1;
        tick(1);
        flush = 1'b0; eu_ready = 1'b0;
        chk("fl_valid", eu_valid, 0);
        chk("fl_free", rs_free_en, 0);
        chk("fl_cnt", issued_cnt, 0);
        tick(2);
        chk("fl_repick_valid", eu_valid, 1);
        chk("fl_repick_tag", eu_tag, 3);

        do_reset();
        set_cand(16'h0020);
        eu_ready = 1'b1;
        tick(1);
        set_cand(16'h0000);
        tick(3);
        chk("loss_valid", eu_valid, 0);
        chk("loss_busy", busy, 0);

        do_reset();
        stall = 1'b1;
        set_cand(16'hFFFF);
        tick(5);
        chk("stall_busy", busy, 0);
        stall = 1'b0;

        do_reset();
        set_cand(16'h8001);
        eu_ready = 1'b1;
        tick(49);
        chk("wrap_cnt", issued_cnt, 0);
        chk("wrap_accepts", acc_tags.size(), 16);
        if (acc_tags.size() >= 3) begin
            chk("wrap_tag1", acc_tags[1], 15);
            chk("wrap_tag2", acc_tags[2], 0);
        end

        for (int c = 0; c < 3000; c++) begin
            rs_busy  = D'($urandom);
            rs_ready = D'($urandom) | D'($urandom);
            eu_ready = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 7) == 0);
            flush    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, D - 1)] = res_st_cell_t'({$urandom, $urandom});
            if (c == 1500) rst_n = 1'b0;
            if (c == 1502) rst_n = 1'b1;
            tick(1);
        end
        flush = 1'b0; stall = 1'b0; eu_ready = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
